// File: rtl/conv_weight_fetch_seq.sv
// Weight ROM fetch sequencer: walks an address window for a number of passes, absorbs ROM
// read latency with a tag pipeline and streams words through a credit-controlled buffer.
module conv_weight_fetch_seq #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 144,
   parameter int unsigned ROM_LAT    = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH-1:0] len_m1_i,
   input  logic [7:0]            repeat_m1_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_rd_data_i,
   output logic [DATA_WIDTH-1:0] w_data_o,
   output logic                  w_valid_o,
   input  logic                  w_ready_i,
   output logic                  w_last_o
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SumW = CntW + 2;

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

   typedef struct packed {
      logic valid;
      logic last_pass;
      logic last_job;
   } tok_t;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] word_q, word_d;
   logic [7:0]            pass_q, pass_d;
   logic [ADDR_WIDTH-1:0] base_q, len_q;
   logic [7:0]            rep_q;

   tok_t [ROM_LAT-1:0] tok_q, tok_d;
   tok_t               emerge;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  last_pass_mem_q [FIFO_DEPTH];
   logic                  last_job_mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;

   logic            load, issue, push, pop;
   logic            last_word, last_pass, credit_ok, head_last_job;
   logic [SumW-1:0] inflight;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign last_word     = (word_q == len_q);
   assign last_pass     = (pass_q == rep_q);
   assign emerge        = tok_q[ROM_LAT-1];
   assign push          = emerge.valid;
   assign w_valid_o     = (cnt_q != '0);
   assign pop           = w_valid_o & w_ready_i;
   assign head_last_job = last_job_mem_q[rd_ptr_q];

   // Tokens still inside the ROM pipeline hold a buffer credit until they land in the FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < ROM_LAT; i++) begin
         inflight = inflight + SumW'(tok_q[i].valid);
      end
   end

   assign credit_ok = (SumW'(cnt_q) + inflight) < SumW'(FIFO_DEPTH);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               load    = 1'b1;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (last_word && last_pass) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (pop && head_last_job) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (abort_i) begin
         state_d = StIdle;
         load    = 1'b0;
         issue   = 1'b0;
      end
   end

   always_comb begin
      addr_d = addr_q;
      word_d = word_q;
      pass_d = pass_q;
      if (load) begin
         addr_d = base_addr_i;
         word_d = '0;
         pass_d = '0;
      end else if (issue) begin
         if (last_word) begin
            addr_d = base_q;
            word_d = '0;
            pass_d = pass_q + 8'd1;
         end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            word_d = word_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_comb begin
      tok_d = '0;
      if (!abort_i) begin
         tok_d[0].valid     = issue;
         tok_d[0].last_pass = issue & last_word;
         tok_d[0].last_job  = issue & last_word & last_pass;
         for (int i = 1; i < ROM_LAT; i++) begin
            tok_d[i] = tok_q[i-1];
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (abort_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         word_q   <= '0;
         pass_q   <= '0;
         base_q   <= '0;
         len_q    <= '0;
         rep_q    <= '0;
         tok_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         word_q   <= word_d;
         pass_q   <= pass_d;
         tok_q    <= tok_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (load) begin
            base_q <= base_addr_i;
            len_q  <= len_m1_i;
            rep_q  <= repeat_m1_i;
         end
      end
   end

   // Storage needs no reset: the read port is gated by the occupancy count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q]           <= rom_rd_data_i;
         last_pass_mem_q[wr_ptr_q] <= emerge.last_pass;
         last_job_mem_q[wr_ptr_q]  <= emerge.last_job;
      end
   end

   assign w_data_o   = w_valid_o ? mem_q[rd_ptr_q] : '0;
   assign w_last_o   = w_valid_o & last_pass_mem_q[rd_ptr_q];
   assign rom_addr_o = addr_q;
   assign busy_o     = (state_q != StIdle);
   assign done_o     = (state_q == StDone);

endmodule

// File: doc/conv_weight_fetch_seq.md
# conv_weight_fetch_seq

Sequencer for the convolution weight ROM. On a per-layer `start`, it walks a contiguous window of ROM addresses and replays the window a programmable number of passes (one per output tile). It absorbs the ROM's fixed read latency and presents weight words to the PE array over a valid/ready stream with a small credit-controlled buffer. It sits between the layer controller and the weight ROM instance (8-bit address, 144-bit word, unregistered output).

## Interface
- `ADDR_WIDTH`, 8: ROM address width.
- `DATA_WIDTH`, 144: ROM/stream word width.
- `ROM_LAT`, 1: ROM read latency in cycles; legal values 1 or 2.
- `FIFO_DEPTH`, 4: output buffer entries; must be ≥ ROM_LAT+2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `abort`  in  1  cancel job; synchronous.
- `base_addr`  in  ADDR_WIDTH  first ROM address of the window; latched at start.
- `len_m1`  in  ADDR_WIDTH  words per pass minus 1; latched at start.
- `repeat_m1`  in  8  passes minus 1; latched at start.
- `busy`  out  1  job active.
- `done`  out  1  one-cycle pulse when the job completes.
- `rom_addr`  out  ADDR_WIDTH  ROM address; register output.
- `rom_rd_data`  in  DATA_WIDTH  ROM read data, valid ROM_LAT cycles after the address cycle.
- `w_data`  out  DATA_WIDTH  weight word (buffer head).
- `w_valid`  out  1  stream valid.
- `w_ready`  in  1  stream ready.
- `w_last`  out  1  marks the last word of each pass.

## Operation
- FSM states:
  - IDLE: `start` & !`abort` latches the inputs, loads the address counter with `base_addr`, clears the word and pass counters, then goes to FETCH.
  - FETCH: issues reads.
    - Issue occurs in a cycle when `fifo_count + inflight < FIFO_DEPTH`. A pop in the same cycle is not credited.
    - On issue, the address counter increments modulo 2^ADDR_WIDTH.
    - When the word counter equals `len_m1`, the address reloads to `base_addr` and the pass counter increments.
    - Issuing the final word of the final pass moves the FSM to DRAIN.
  - DRAIN: no issues. When the final word is handshaken, the block pulses `done` and returns to IDLE.
- Tag pipeline: each issue pushes a token carrying {last_of_pass, last_of_job} into a ROM_LAT-deep shift register. The token's emergence writes `rom_rd_data` plus its tags into the FIFO.
- Stream rules:
  - `w_valid` = FIFO non-empty.
  - A pop occurs on `w_valid & w_ready`.
  - `w_data`/`w_last` are stable while `w_valid & !w_ready`.
- Abort:
  - Any state goes to IDLE next cycle.
  - FIFO is flushed and in-flight tokens are discarded.
  - `done` is not pulsed.
- Priority rules:
  - `abort` beats `start` and beats the final handshake in the same cycle.
  - `start` while not in IDLE is ignored.
- `len_m1`=0: every word has `w_last`. Address wrap past 2^ADDR_WIDTH−1 is to 0 and is legal.
- `rom_addr` holds its value when no issue occurs.

## Timing
- Reset values (asynchronous): state IDLE; all counters, FIFO pointers and tokens 0; `rom_addr`=0; `busy`=`done`=`w_valid`=`w_last`=0; `w_data`=0.
- Cycle numbering: the start-accept cycle is cycle 0.
  - `busy` is high from cycle 1 through the `done` cycle inclusive.
  - `rom_addr`=`base_addr` is first issued in cycle 1.
- The first `w_valid` appears in cycle 2+ROM_LAT.
- With `w_ready` held high, throughput is 1 word/cycle with no bubbles between passes.
- `done` occurs in the cycle after the final handshake. `busy` falls the cycle after `done`.
- Job length with no stall = (len_m1+1)(repeat_m1+1) + ROM_LAT + 2 cycles, up to and including `done`.
- Abort: `busy`/`w_valid` are low in the cycle after `abort`. A new `start` is accepted the following cycle.

## Test plan
- Basic job:
  - Stimulus: ROM_LAT=1, base=0x10, len_m1=3, repeat_m1=0, `w_ready`=1.
  - Required: `rom_addr` 0x10..0x13 in cycles 1–4; `w_valid` in cycles 3–6 carrying ROM[0x10..0x13]; `w_last` only in cycle 6; `done` in cycle 7; `busy` high in cycles 1–7.
- Address wrap:
  - Stimulus: base=0xFE, len_m1=3.
  - Required: addresses FE, FF, 00, 01; data in that order.
- Repeat passes:
  - Stimulus: base=0x20, len_m1=1, repeat_m1=2.
  - Required: words ROM[20,21,20,21,20,21]; `w_last` on words 2, 4 and 6; a single `done`.
- Backpressure:
  - Stimulus: `w_ready`=0 for 10 cycles from cycle 2, then random toggling.
  - Required: issues stop at 4 outstanding; no loss or duplication; `w_data` stable while stalled; correct order end-to-end.
- Abort:
  - Stimulus: assert `abort` after the 2nd handshake of a len_m1=7 job, with `start` also asserted in that cycle.
  - Required: `busy`/`w_valid` low next cycle; no `done`. A subsequent start with base=0x40 outputs ROM[0x40..] with no stale words.
- Reset mid-job:
  - Stimulus: drop `rst_n` during FETCH with the FIFO partly full.
  - Required: all outputs 0 immediately; after release the block is IDLE and the next job is correct.
